// File: rtl/pwm_meter_pkg.sv
// Shared types and defaults for the PWM duty meter and related input monitors.
package pwm_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } meter_state_t;

  localparam logic [1:0] TREND_NONE = 2'b00;
  localparam logic [1:0] TREND_UP   = 2'b01;
  localparam logic [1:0] TREND_DOWN = 2'b10;

  localparam int DEFAULT_CNT_W       = 20;
  localparam int DEFAULT_TIMEOUT_MAX = 100000;

  // Maps a magnitude comparison of new vs previous high time onto a trend code.
  function automatic logic [1:0] trend_code(input logic greater, input logic less);
    if (greater)   return TREND_UP;
    else if (less) return TREND_DOWN;
    else           return TREND_NONE;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus history flop; yields the synchronized level and a
// single-cycle rising-edge pulse.
module pwm_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pwm_in,
  output logic lvl,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an external PWM input per rising edge and
// flags a stuck input. Optional brightness trend output: PWM_METER_TREND_EN.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int               CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(DEFAULT_TIMEOUT_MAX)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [1:0]       trend
);

  localparam logic [CNT_W-1:0] IDLE_LAST = TIMEOUT_MAX - 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic lvl;
  logic rise;

  pwm_edge_sync u_edge_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pwm_in  (pwm_in),
    .lvl     (lvl),
    .rise    (rise)
  );

  meter_state_t     state_reg,       state_next;
  logic [CNT_W-1:0] period_cnt_reg,  period_cnt_next;
  logic [CNT_W-1:0] high_cnt_reg,    high_cnt_next;
  logic [CNT_W-1:0] idle_cnt_reg,    idle_cnt_next;
  logic [CNT_W-1:0] meas_period_reg, meas_period_next;
  logic [CNT_W-1:0] meas_high_reg,   meas_high_next;
  logic             meas_valid_reg,  meas_valid_next;
  logic             stuck_reg,       stuck_next;
  logic             stuck_level_reg, stuck_level_next;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg       <= IDLE;
      period_cnt_reg  <= '0;
      high_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
      meas_period_reg <= '0;
      meas_high_reg   <= '0;
      meas_valid_reg  <= 1'b0;
      stuck_reg       <= 1'b0;
      stuck_level_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      period_cnt_reg  <= period_cnt_next;
      high_cnt_reg    <= high_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      meas_period_reg <= meas_period_next;
      meas_high_reg   <= meas_high_next;
      meas_valid_reg  <= meas_valid_next;
      stuck_reg       <= stuck_next;
      stuck_level_reg <= stuck_level_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    period_cnt_next  = period_cnt_reg;
    high_cnt_next    = high_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    meas_period_next = meas_period_reg;
    meas_high_next   = meas_high_reg;
    meas_valid_next  = 1'b0;
    stuck_next       = stuck_reg;
    stuck_level_next = stuck_level_reg;

    if (rise) begin
      stuck_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        period_cnt_next = '0;
        high_cnt_next   = '0;
        if (rise) begin
          state_next      = MEAS;
          period_cnt_next = CNT_ONE;
          high_cnt_next   = CNT_ONE;
          idle_cnt_next   = '0;
        end else if (!stuck_reg) begin
          // Idle watchdog only runs until the first stuck report.
          if (idle_cnt_reg == IDLE_LAST) begin
            stuck_next       = 1'b1;
            stuck_level_next = lvl;
            idle_cnt_next    = '0;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end

      MEAS: begin
        if (rise) begin
          meas_period_next = period_cnt_reg;
          meas_high_next   = high_cnt_reg;
          meas_valid_next  = 1'b1;
          period_cnt_next  = CNT_ONE;
          high_cnt_next    = CNT_ONE;
        end else if (period_cnt_reg == TIMEOUT_MAX) begin
          // Partial period is abandoned; last report stays on the outputs.
          state_next       = IDLE;
          period_cnt_next  = '0;
          high_cnt_next    = '0;
          idle_cnt_next    = '0;
          stuck_next       = 1'b1;
          stuck_level_next = lvl;
        end else begin
          period_cnt_next = period_cnt_reg + 1'b1;
          high_cnt_next   = high_cnt_reg + {{(CNT_W-1){1'b0}}, lvl};
        end
      end

      default: begin
        state_next      = IDLE;
        period_cnt_next = '0;
        high_cnt_next   = '0;
      end
    endcase
  end

  assign meas_period = meas_period_reg;
  assign meas_high   = meas_high_reg;
  assign meas_valid  = meas_valid_reg;
  assign stuck       = stuck_reg;
  assign stuck_level = stuck_level_reg;

`ifdef PWM_METER_TREND_EN
  logic             report;
  logic             enter_idle;
  logic [CNT_W-1:0] prev_high_reg;
  logic             prev_valid_reg;
  logic [1:0]       trend_reg;

  assign report     = (state_reg == MEAS) && rise;
  assign enter_idle = (state_reg == MEAS) && !rise && (period_cnt_reg == TIMEOUT_MAX);

  // The first report after reset or timeout has no reference and reads as equal.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_high_reg  <= '0;
      prev_valid_reg <= 1'b0;
      trend_reg      <= TREND_NONE;
    end else if (report) begin
      prev_high_reg  <= high_cnt_reg;
      prev_valid_reg <= 1'b1;
      trend_reg      <= prev_valid_reg ?
                        trend_code(high_cnt_reg > prev_high_reg, high_cnt_reg < prev_high_reg) :
                        TREND_NONE;
    end else if (enter_idle) begin
      prev_valid_reg <= 1'b0;
    end
  end

  assign trend = trend_reg;
`else
  assign trend = TREND_NONE;
`endif

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: table of PWM periods plus hand-written
// reset, stuck and timeout sequences.
module tb_pwm_duty_meter;

  localparam int CNT_W = 20;
  localparam int TMO   = 120;
  localparam int NV    = 12;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             pwm_in;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;
  logic [1:0]       trend;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_MAX (20'(TMO))
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .pwm_in      (pwm_in),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .trend       (trend)
  );

  always #5 sys_clk = ~sys_clk;

  int cycle = 0;
  always @(posedge sys_clk) cycle <= cycle + 1;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [1:0]       trend;
    int               cyc;
  } rpt_t;

  typedef struct {
    int         grp;
    int         period;
    int         high;
    int         exp_period;
    int         exp_high;
    logic [1:0] exp_trend;
  } vec_t;

  rpt_t rpt_q[$];
  vec_t vecs[NV];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture every strobe; a strobe on two consecutive cycles is an error.
  initial begin
    logic valid_d;
    rpt_t r;
    valid_d = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (meas_valid === 1'b1) begin
        check("valid_gap", {31'd0, valid_d}, 32'd0);
        r.period = meas_period;
        r.high   = meas_high;
        r.trend  = trend;
        r.cyc    = cycle;
        rpt_q.push_back(r);
      end
      valid_d = (meas_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [1:0] exp_tr(input logic [1:0] t);
`ifdef PWM_METER_TREND_EN
    return t;
`else
    return (t === 2'bxx) ? 2'b11 : 2'b00;
`endif
  endfunction

  task automatic do_reset(input logic level);
    sys_rst = 1'b1;
    pwm_in  = level;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_period", 32'(meas_period), 32'd0);
    check("rst_high",   32'(meas_high),   32'd0);
    check("rst_valid",  {31'd0, meas_valid},  32'd0);
    check("rst_stuck",  {31'd0, stuck},       32'd0);
    check("rst_level",  {31'd0, stuck_level}, 32'd0);
    check("rst_trend",  {30'd0, trend},       32'd0);
    sys_rst = 1'b0;
    rpt_q.delete();
  endtask

  task automatic drive_period(input int p, input int h);
    pwm_in = 1'b1;
    repeat (h) @(posedge sys_clk);
    #1 pwm_in = 1'b0;
    repeat (p - h) @(posedge sys_clk);
    #1;
  endtask

  // Extra rising edge so the last driven period gets reported.
  task automatic close_edge();
    pwm_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 pwm_in = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_table(input int s, input int e);
    rpt_t r;
    int   prev_cyc;
    check("n_reports", rpt_q.size(), e - s + 1);
    prev_cyc = 0;
    for (int k = s; k <= e; k++) begin
      if (rpt_q.size() == 0) break;
      r = rpt_q.pop_front();
      $display("[TB] row %0d report period=%0d high=%0d trend=%b cycle=%0d",
               k, r.period, r.high, r.trend, r.cyc);
      check("tbl_period", 32'(r.period), vecs[k].exp_period);
      check("tbl_high",   32'(r.high),   vecs[k].exp_high);
      check("tbl_trend",  {30'd0, r.trend}, {30'd0, exp_tr(vecs[k].exp_trend)});
      if (k > s) check("tbl_spacing", r.cyc - prev_cyc, vecs[k].exp_period);
      prev_cyc = r.cyc;
    end
    check("tbl_stuck", {31'd0, stuck}, 32'd0);
  endtask

  task automatic check_uniform(input int n, input int per, input int hi);
    rpt_t r;
    int   prev_cyc;
    check("n_reports", rpt_q.size(), n);
    prev_cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (rpt_q.size() == 0) break;
      r = rpt_q.pop_front();
      $display("[TB] seq report period=%0d high=%0d trend=%b cycle=%0d",
               r.period, r.high, r.trend, r.cyc);
      check("seq_period", 32'(r.period), per);
      check("seq_high",   32'(r.high),   hi);
      check("seq_trend",  {30'd0, r.trend}, 32'd0);
      if (k > 0) check("seq_spacing", r.cyc - prev_cyc, per);
      prev_cyc = r.cyc;
    end
  endtask

  initial begin
    int  gstart;
    int  n;
    bit  first;
    bit  last;

    vecs[0]  = '{0, 100, 30, 100, 30, 2'b00};
    vecs[1]  = '{0, 100, 30, 100, 30, 2'b00};
    vecs[2]  = '{0, 100, 30, 100, 30, 2'b00};
    vecs[3]  = '{0, 100, 30, 100, 30, 2'b00};
    vecs[4]  = '{0, 100, 30, 100, 30, 2'b00};
    vecs[5]  = '{1, 100,  1, 100,  1, 2'b00};
    vecs[6]  = '{1, 100, 99, 100, 99, 2'b01};
    vecs[7]  = '{2, 100, 10, 100, 10, 2'b00};
    vecs[8]  = '{2, 100, 20, 100, 20, 2'b01};
    vecs[9]  = '{2, 100, 20, 100, 20, 2'b00};
    vecs[10] = '{2, 100, 15, 100, 15, 2'b10};
    vecs[11] = '{3, 120, 60, 120, 60, 2'b00};

    sys_rst = 1'b1;
    pwm_in  = 1'b0;
    gstart  = 0;

    for (int i = 0; i < NV; i++) begin
      first = (i == 0) ? 1'b1 : (vecs[i].grp != vecs[i-1].grp);
      if (first) begin
        do_reset(1'b0);
        gstart = i;
      end
      drive_period(vecs[i].period, vecs[i].high);
      last = (i == NV - 1) ? 1'b1 : (vecs[i+1].grp != vecs[i].grp);
      if (last) begin
        close_edge();
        check_table(gstart, i);
      end
    end

    // Asynchronous reset in the middle of a period.
    do_reset(1'b0);
    drive_period(100, 30);
    pwm_in = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1 pwm_in = 1'b0;
    repeat (30) @(posedge sys_clk);
    #1;
    check("pre_rst_period", 32'(meas_period), 32'd100);
    check("pre_rst_high",   32'(meas_high),   32'd30);
    sys_rst = 1'b1;
    #1;
    check("async_rst_period", 32'(meas_period), 32'd0);
    check("async_rst_high",   32'(meas_high),   32'd0);
    check("async_rst_valid",  {31'd0, meas_valid}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    rpt_q.delete();
    repeat (38) @(posedge sys_clk);
    #1;
    drive_period(100, 30);
    drive_period(100, 30);
    close_edge();
    check_uniform(2, 100, 30);

    // Input low forever after reset: idle watchdog.
    do_reset(1'b0);
    n = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge sys_clk);
      n = c;
      if (stuck === 1'b1) break;
    end
    check("idle_stuck",       {31'd0, stuck},       32'd1);
    check("idle_stuck_level", {31'd0, stuck_level}, 32'd0);
    check("idle_stuck_time",  {31'd0, (n >= 110 && n <= 135)}, 32'd1);
    check("idle_no_report",   rpt_q.size(), 32'd0);

    // Input high from reset: one edge, then measurement timeout.
    @(posedge sys_clk);
    #1;
    do_reset(1'b1);
    n = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge sys_clk);
      n = c;
      if (stuck === 1'b1) break;
    end
    check("hi_stuck",       {31'd0, stuck},       32'd1);
    check("hi_stuck_level", {31'd0, stuck_level}, 32'd1);
    check("hi_stuck_time",  {31'd0, (n >= 110 && n <= 135)}, 32'd1);
    check("hi_no_report",   rpt_q.size(), 32'd0);
    check("hi_period_hold", 32'(meas_period), 32'd0);
    @(posedge sys_clk);
    #1 pwm_in = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    check("hi_stuck_held", {31'd0, stuck}, 32'd1);
    pwm_in = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    check("hi_stuck_cleared", {31'd0, stuck}, 32'd0);
    repeat (35) @(posedge sys_clk);
    #1 pwm_in = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    drive_period(100, 40);
    close_edge();
    check_uniform(2, 100, 40);
    check("hi_final_stuck", {31'd0, stuck}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
